// File: rtl/orbit_seq_pkg.sv
// Shared constants, mode selector type and side-orbit step for orbit_seq_fsm.
package orbit_seq_pkg;

  localparam int unsigned MAX_WIDTH = 16;

  typedef logic [0:0] orbit_mode_t;

  localparam orbit_mode_t MODE_JOHNSON = 1'b0;
  localparam orbit_mode_t MODE_BINARY  = 1'b1;

  // Shift in a one from the LSB side; callers truncate to their own width.
  function automatic logic [MAX_WIDTH-1:0] side_next(input logic [MAX_WIDTH-1:0] x);
    return {x[MAX_WIDTH-2:0], 1'b1};
  endfunction

endpackage

// File: rtl/orbit_next.sv
// Combinational main-orbit step of the upper state bits (Johnson or binary increment).
module orbit_next
  import orbit_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter orbit_mode_t MODE  = MODE_JOHNSON
) (
  input  logic [WIDTH-2:0] u,
  output logic [WIDTH-2:0] u_next
);

  if (MODE == MODE_BINARY) begin : g_binary
    assign u_next = u + {{(WIDTH-2){1'b0}}, 1'b1};
  end else begin : g_johnson
    assign u_next = {u[WIDTH-3:0], ~u[WIDTH-2]};
  end

endmodule

// File: rtl/orbit_seq_fsm.sv
// Orbit-state benchmark FSM: main orbit, side orbit into an all-ones trap, wrap pulse/counter.
// Optional build macro TRAP_RECOVER_EN: trap with i1=1 returns to state 0.
module orbit_seq_fsm
  import orbit_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter orbit_mode_t MODE  = MODE_JOHNSON,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i1,
  input  logic             inj,
  output logic             z1,
  output logic [WIDTH-1:0] state,
  output logic             wrap,
  output logic [CNT_W-1:0] orbits
);

  logic [WIDTH-1:0] x_q, x_d;
  logic             landed_q, landed_d;
  logic             wrap_q;
  logic [CNT_W-1:0] orbits_q, orbits_d;
  logic [WIDTH-2:0] u_next;

  orbit_next #(
    .WIDTH(WIDTH),
    .MODE (MODE)
  ) u_orbit_next (
    .u     (x_q[WIDTH-1:1]),
    .u_next(u_next)
  );

  // landed_q marks the cycle spent on 0 after completing an orbit; wrap and the
  // counter follow it by one edge.
  always_comb begin
    x_d      = x_q;
    landed_d = 1'b0;
    orbits_d = orbits_q;
    if (landed_q) begin
      orbits_d = orbits_q + CNT_W'(1);
    end
    if (!x_q[0]) begin
      if (inj) begin
        x_d = x_q | WIDTH'(1);
      end else if (i1) begin
        x_d      = {u_next, 1'b0};
        landed_d = (u_next == '0) && (x_q != '0);
      end
    end else if (i1) begin
`ifdef TRAP_RECOVER_EN
      if (&x_q) begin
        x_d = '0;
      end else begin
        x_d = WIDTH'(side_next(MAX_WIDTH'(x_q)));
      end
`else
      x_d = WIDTH'(side_next(MAX_WIDTH'(x_q)));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      landed_q <= 1'b0;
      wrap_q   <= 1'b0;
      orbits_q <= '0;
    end else begin
      x_q      <= x_d;
      landed_q <= landed_d;
      wrap_q   <= landed_q;
      orbits_q <= orbits_d;
    end
  end

  assign state  = x_q;
  assign z1     = x_q[WIDTH-1] & x_q[0];
  assign wrap   = wrap_q;
  assign orbits = orbits_q;

endmodule

// File: tb/tb_orbit_seq_fsm.sv
// Self-checking bench for orbit_seq_fsm: vector table, directed sequences, random vs model.
module tb_orbit_seq_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // d0: WIDTH=3 Johnson, 2-bit counter; d1: WIDTH=4 binary, 4-bit counter
  logic       r0, a0, j0, z0, w0;
  logic [2:0] st0;
  logic [1:0] o0;
  logic       r1, a1, j1, z1b, w1;
  logic [3:0] st1;
  logic [3:0] o1;

  orbit_seq_fsm #(.WIDTH(3), .MODE(1'b0), .CNT_W(2)) dut0 (
    .clk(clk), .reset(r0), .i1(a0), .inj(j0), .z1(z0), .state(st0), .wrap(w0), .orbits(o0)
  );
  orbit_seq_fsm #(.WIDTH(4), .MODE(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(r1), .i1(a1), .inj(j1), .z1(z1b), .state(st1), .wrap(w1), .orbits(o1)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst; logic i1; logic inj;
    int st; int z; int w; int orb;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic i1, input logic inj,
                              input int st, input int z, input int w, input int orb);
    vec_t v;
    v.rst = rst; v.i1 = i1; v.inj = inj; v.st = st; v.z = z; v.w = w; v.orb = orb;
    return v;
  endfunction

  // Reference model: main orbit as a position index, side orbit as a plain value.
  int m_w[2]    = '{3, 4};
  int m_mode[2] = '{0, 1};
  int m_cw[2]   = '{2, 4};
  int m_side[2], m_pos[2], m_val[2], m_land[2], m_wrap[2], m_orb[2];

  function automatic int main_val(input int w, input int mode, input int pos);
    int n = w - 1;
    if (mode == 1) return pos << 1;
    if (pos <= n) return ((1 << pos) - 1) << 1;
    return ((((1 << n) - 1) << (pos - n)) & ((1 << n) - 1)) << 1;
  endfunction

  function automatic int orbit_len(input int w, input int mode);
    return (mode == 1) ? (1 << (w - 1)) : 2 * (w - 1);
  endfunction

  function automatic int exp_state(input int d);
    return m_side[d] ? m_val[d] : main_val(m_w[d], m_mode[d], m_pos[d]);
  endfunction

  task automatic model_step(input int d, input bit rst, input bit i1, input bit inj);
    int mask = (1 << m_w[d]) - 1;
    if (rst) begin
      m_side[d] = 0; m_pos[d] = 0; m_val[d] = 0;
      m_land[d] = 0; m_wrap[d] = 0; m_orb[d] = 0;
      return;
    end
    m_wrap[d] = m_land[d];
    if (m_land[d] != 0) m_orb[d] = (m_orb[d] + 1) % (1 << m_cw[d]);
    m_land[d] = 0;
    if (m_side[d] == 0) begin
      if (inj) begin
        m_val[d]  = main_val(m_w[d], m_mode[d], m_pos[d]) | 1;
        m_side[d] = 1;
      end else if (i1) begin
        m_pos[d] = (m_pos[d] + 1) % orbit_len(m_w[d], m_mode[d]);
        if (m_pos[d] == 0) m_land[d] = 1;
      end
    end else if (i1) begin
`ifdef TRAP_RECOVER_EN
      if (m_val[d] == mask) begin
        m_side[d] = 0; m_pos[d] = 0; m_val[d] = 0;
      end else begin
        m_val[d] = ((m_val[d] << 1) | 1) & mask;
      end
`else
      m_val[d] = ((m_val[d] << 1) | 1) & mask;
`endif
    end
  endtask

  vec_t tbl[16];

  initial begin
    int pulses;
    int exp_orb;
    int es;

    r0 = 1'b1; a0 = 1'b0; j0 = 1'b0;
    r1 = 1'b1; a1 = 1'b0; j1 = 1'b0;

    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 2, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 6, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 4, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 2, 0, 1, 1);
    tbl[6]  = mk(0, 0, 0, 2, 0, 0, 1);
    tbl[7]  = mk(0, 1, 1, 3, 0, 0, 1);
    tbl[8]  = mk(0, 1, 0, 7, 1, 0, 1);
`ifdef TRAP_RECOVER_EN
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 1);
`else
    tbl[9]  = mk(0, 1, 0, 7, 1, 0, 1);
`endif
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 0, 2, 0, 0, 0);
    tbl[12] = mk(0, 1, 0, 6, 0, 0, 0);
    tbl[13] = mk(0, 0, 1, 7, 1, 0, 0);
    tbl[14] = mk(0, 0, 0, 7, 1, 0, 0);
    tbl[15] = mk(1, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      r0 = tbl[i].rst; a0 = tbl[i].i1; j0 = tbl[i].inj;
      cyc();
      chk($sformatf("vec%0d_state", i), int'(st0), tbl[i].st);
      chk($sformatf("vec%0d_z1", i), int'(z0), tbl[i].z);
      chk($sformatf("vec%0d_wrap", i), int'(w0), tbl[i].w);
      chk($sformatf("vec%0d_orbits", i), int'(o0), tbl[i].orb);
    end

    // Five full Johnson orbits on the 2-bit counter: 1,2,3,0,1.
    r0 = 1'b0; a0 = 1'b1; j0 = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 21; k++) begin
      cyc();
      chk($sformatf("orb5_z1_%0d", k), int'(z0), 0);
      if (w0) begin
        pulses++;
        chk($sformatf("orb5_count_%0d", pulses), int'(o0), pulses % 4);
      end
    end
    chk("orb5_pulses", pulses, 5);
    chk("orb5_final_orbits", int'(o0), 1);
    a0 = 1'b0;

    // Binary WIDTH=4 orbit of 8 advances, then a 3-cycle hold.
    r1 = 1'b1;
    cyc();
    r1 = 1'b0; a1 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk($sformatf("bin_state_%0d", k), int'(st1), (2 * k) % 16);
      chk($sformatf("bin_wrap_%0d", k), int'(w1), (k == 9) ? 1 : 0);
    end
    chk("bin_orbits", int'(o1), 1);
    a1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("bin_hold_state_%0d", k), int'(st1), 2);
      chk($sformatf("bin_hold_wrap_%0d", k), int'(w1), 0);
    end

    // Randomized run of both instances against the model.
    r0 = 1'b1; r1 = 1'b1; a0 = 1'b0; a1 = 1'b0; j0 = 1'b0; j1 = 1'b0;
    model_step(0, 1, 0, 0);
    model_step(1, 1, 0, 0);
    cyc();
    for (int k = 0; k < 3000; k++) begin
      r0 = ($urandom_range(63) == 0);
      a0 = $urandom_range(1);
      j0 = ($urandom_range(7) == 0);
      r1 = ($urandom_range(63) == 0);
      a1 = $urandom_range(1);
      j1 = ($urandom_range(7) == 0);
      model_step(0, r0, a0, j0);
      model_step(1, r1, a1, j1);
      cyc();
      es = exp_state(0);
      chk($sformatf("rnd0_state_%0d", k), int'(st0), es);
      chk($sformatf("rnd0_z1_%0d", k), int'(z0), (m_side[0] != 0 && es >= 4) ? 1 : 0);
      chk($sformatf("rnd0_wrap_%0d", k), int'(w0), m_wrap[0]);
      chk($sformatf("rnd0_orbits_%0d", k), int'(o0), m_orb[0]);
      es = exp_state(1);
      chk($sformatf("rnd1_state_%0d", k), int'(st1), es);
      chk($sformatf("rnd1_z1_%0d", k), int'(z1b), (m_side[1] != 0 && es >= 8) ? 1 : 0);
      chk($sformatf("rnd1_wrap_%0d", k), int'(w1), m_wrap[1]);
      exp_orb = m_orb[1];
      chk($sformatf("rnd1_orbits_%0d", k), int'(o1), exp_orb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
